// File: rtl/vga_pixel_fetch.sv
// 640x480 raster scanner: fetches one 2-bit index per pixel from a double-buffered
// frame buffer, presents it with aligned syncs, and swaps front buffer at vblank start.
module vga_pixel_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIX_W    = 19
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [PIX_W:0]   fb_addr,
  input  logic [1:0]       fb_rdata,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             buf_sel,
  output logic [1:0]       color,
  output logic             hs,
  output logic             vs,
  output logic             blank_n,
  output logic             pix_tick
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
  localparam logic [HW-1:0]    H_LAST   = HW'(HT - 1);
  localparam logic [HW-1:0]    H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]    HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]    HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]    H_ONE    = HW'(1);
  localparam logic [VW-1:0]    V_LAST   = VW'(VT - 1);
  localparam logic [VW-1:0]    V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]    V_PRE_BL = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]    VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]    VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]    V_ONE    = VW'(1);
  localparam logic [PIX_W-1:0] ADDR_ONE = PIX_W'(1);

  logic [DW-1:0]    div_q, div_d;
  logic [HW-1:0]    hc_q, hc_d;
  logic [VW-1:0]    vc_q, vc_d;
  logic [PIX_W-1:0] pix_addr_q, pix_addr_d;
  logic             buf_sel_q, buf_sel_d;
  logic             pending_q, pending_d;
  logic             swap_ack_q, swap_ack_d;
  logic [1:0]       color_q, color_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;

  logic tick;
  logic active;
  logic hs_raw;
  logic vs_raw;
  logic h_wrap;
  logic v_wrap;
  logic swap_evt;

  // Reset gates the tick so no raster step or output update slips through on a reset cycle.
  always_comb begin
    tick     = (div_q == DIV_LAST) && !Reset;
    active   = (hc_q < H_ACT) && (vc_q < V_ACT);
    hs_raw   = !((hc_q >= HS_BEG) && (hc_q < HS_END));
    vs_raw   = !((vc_q >= VS_BEG) && (vc_q < VS_END));
    h_wrap   = (hc_q == H_LAST);
    v_wrap   = (vc_q == V_LAST);
    swap_evt = tick && h_wrap && (vc_q == V_PRE_BL) && (pending_q || swap_req);
  end

  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
    hc_d       = hc_q;
    vc_d       = vc_q;
    pix_addr_d = pix_addr_q;
    color_d    = color_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    blank_n_d  = blank_n_q;
    if (tick) begin
      hc_d = h_wrap ? '0 : hc_q + H_ONE;
      if (h_wrap) begin
        vc_d = v_wrap ? '0 : vc_q + V_ONE;
      end
      // Linear address without a multiplier: count active pixels, clear at frame wrap.
      if (h_wrap && v_wrap) begin
        pix_addr_d = '0;
      end else if (active) begin
        pix_addr_d = pix_addr_q + ADDR_ONE;
      end
      // RAM data for the position being left arrived one Clk after its address settled.
      color_d   = active ? fb_rdata : 2'b00;
      hs_d      = hs_raw;
      vs_d      = vs_raw;
      blank_n_d = active;
    end
  end

  always_comb begin
    buf_sel_d  = buf_sel_q ^ swap_evt;
    swap_ack_d = swap_evt;
    pending_d  = swap_evt ? 1'b0 : (pending_q || swap_req);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q      <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
      pix_addr_q <= '0;
      buf_sel_q  <= 1'b0;
      pending_q  <= 1'b0;
      swap_ack_q <= 1'b0;
      color_q    <= 2'b00;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      pix_addr_q <= pix_addr_d;
      buf_sel_q  <= buf_sel_d;
      pending_q  <= pending_d;
      swap_ack_q <= swap_ack_d;
      color_q    <= color_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_n_q  <= blank_n_d;
    end
  end

  assign fb_addr  = {buf_sel_q, pix_addr_q};
  assign buf_sel  = buf_sel_q;
  assign swap_ack = swap_ack_q;
  assign color    = color_q;
  assign hs       = hs_q;
  assign vs       = vs_q;
  assign blank_n  = blank_n_q;
  assign pix_tick = tick;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a shrunken raster; a reference raster model queues the
// expected per-pixel outputs and compares them when the DUT registers them.
module tb_vga_pixel_fetch;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int CD = 2;
  localparam int PW = 7;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * CD;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          swap_req = 1'b0;
  logic [PW:0]   fb_addr;
  logic [1:0]    fb_rdata = 2'b00;
  logic          swap_ack, buf_sel, hs, vs, blank_n, pix_tick;
  logic [1:0]    color;

  int n_chk = 0;
  int n_err = 0;
  int ack_cnt = 0;

  int m_div = 0, m_hc = 0, m_vc = 0;
  bit m_bs = 0, m_pend = 0, m_ack = 0, m_new_out = 0, m_rst_seen = 0;
  logic [4:0] sb[$];

  vga_pixel_fetch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .PIX_W(PW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
    .color(color), .hs(hs), .vs(vs), .blank_n(blank_n), .pix_tick(pix_tick)
  );

  always #5 Clk = ~Clk;

  // Synchronous RAM, 1-Clk latency, contents = low address bits.
  always @(posedge Clk) fb_rdata <= fb_addr[1:0];

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference raster model, advanced on each posedge from the bench's own inputs.
  always @(posedge Clk) begin
    int nhc, nvc, col;
    bit act, hsr, vsr;
    m_new_out = 0;
    m_ack = 0;
    if (Reset) begin
      m_div = 0; m_hc = 0; m_vc = 0;
      m_bs = 0; m_pend = 0; m_rst_seen = 1;
      sb.delete();
    end else begin
      m_rst_seen = 0;
      if (m_div == CD - 1) begin
        act = (m_hc < HA) && (m_vc < VA);
        col = act ? ((m_vc * HA + m_hc) % 4) : 0;
        hsr = !((m_hc >= HA + HF) && (m_hc < HA + HF + HS));
        vsr = !((m_vc >= VA + VF) && (m_vc < VA + VF + VS));
        sb.push_back({col[1:0], hsr, vsr, act});
        m_new_out = 1;
        nhc = (m_hc == HT - 1) ? 0 : m_hc + 1;
        nvc = (m_hc == HT - 1) ? ((m_vc == VT - 1) ? 0 : m_vc + 1) : m_vc;
        if (nhc == 0 && nvc == VA && (m_pend || swap_req)) begin
          m_bs = !m_bs; m_ack = 1; m_pend = 0;
        end else if (swap_req) begin
          m_pend = 1;
        end
        m_hc = nhc; m_vc = nvc; m_div = 0;
      end else begin
        if (swap_req) m_pend = 1;
        m_div++;
      end
    end
  end

  always @(negedge Clk) begin
    logic [4:0] e;
    if (m_rst_seen) begin
      chk("rst_color", color, 0);
      chk("rst_blank_n", blank_n, 0);
      chk("rst_hs", hs, 1);
      chk("rst_vs", vs, 1);
    end
    chk("pix_tick", pix_tick, ((m_div == CD - 1) && !Reset) ? 1 : 0);
    chk("swap_ack", swap_ack, m_ack);
    chk("buf_sel", buf_sel, m_bs);
    chk("fb_addr_bufsel", fb_addr[PW], m_bs);
    if (m_hc < HA && m_vc < VA)
      chk("fb_addr_pix", fb_addr[PW-1:0], (m_vc * HA + m_hc) % (1 << PW));
    if (m_new_out) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("color", color, e[4:3]);
        chk("hs", hs, e[2]);
        chk("vs", vs, e[1]);
        chk("blank_n", blank_n, e[0]);
      end
    end
    if (swap_ack === 1'b1) ack_cnt++;
  end

  task automatic wait_at(input int x, input int y, input int d, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk); #1;
      if (m_hc == x && m_vc == y && m_div == d) return;
    end
    chk("wait_timeout", 0, 1);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(posedge Clk); #1;
    swap_req = 1'b0;
  endtask

  initial begin
    int a0, n;
    bit seen;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    repeat (2 * FRAME_CLK) @(posedge Clk);
    #1 chk("no_swap_two_frames", ack_cnt, 0);

    // Single request mid-frame.
    wait_at(0, 3, 0, 2 * FRAME_CLK);
    a0 = ack_cnt;
    pulse_swap();
    repeat (FRAME_CLK) @(posedge Clk);
    #1 chk("swap_single_ack", ack_cnt - a0, 1);
    chk("swap_single_bufsel", buf_sel, 1);
    repeat (FRAME_CLK) @(posedge Clk);
    #1 chk("bufsel_holds", buf_sel, 1);

    // Three requests in one frame collapse into one swap.
    wait_at(0, 1, 0, 2 * FRAME_CLK);
    a0 = ack_cnt;
    pulse_swap();
    wait_at(0, 3, 0, FRAME_CLK);
    pulse_swap();
    wait_at(0, 5, 0, FRAME_CLK);
    pulse_swap();
    wait_at(0, VA + 1, 0, FRAME_CLK);
    chk("triple_req_one_ack", ack_cnt - a0, 1);
    chk("triple_req_bufsel", buf_sel, 0);

    // Request raised exactly on the swap-event cycle.
    wait_at(HT - 1, VA - 1, CD - 1, 2 * FRAME_CLK);
    a0 = ack_cnt;
    pulse_swap();
    repeat (2 * FRAME_CLK) @(posedge Clk);
    #1 chk("event_req_one_ack", ack_cnt - a0, 1);
    chk("event_req_bufsel", buf_sel, 1);

    // Mid-frame reset.
    wait_at(10, 4, 0, 2 * FRAME_CLK);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("midrst_bufsel", buf_sel, 0);
    chk("midrst_hs", hs, 1);
    chk("midrst_blank_n", blank_n, 0);
    n = 0;
    seen = 0;
    for (int i = 0; i < 4 * HT * CD && !seen; i++) begin
      @(negedge Clk);
      if (pix_tick === 1'b1) n++;
      if (hs === 1'b0) seen = 1;
    end
    chk("first_hs_low_seen", seen, 1);
    chk("first_hs_low_tick", n, HA + HF + 1);

    repeat (FRAME_CLK) @(posedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
